// File: rtl/alu_muldiv_control_pkg.sv
// alu_muldiv_control_pkg: ALUCtl/ALUOp/Funct codes, FSM states and the control decoder
package alu_muldiv_control_pkg;
    localparam logic [2:0] CTL_FORWARD = 3'd0;
    localparam logic [2:0] CTL_OR      = 3'd1;
    localparam logic [2:0] CTL_ADD     = 3'd2;
    localparam logic [2:0] CTL_MFHI    = 3'd3;
    localparam logic [2:0] CTL_MFLO    = 3'd4;
    localparam logic [2:0] CTL_MUL     = 3'd5;
    localparam logic [2:0] CTL_SUB     = 3'd6;
    localparam logic [2:0] CTL_DIV     = 3'd7;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_RES    = 2'b11;

    localparam logic [5:0] F_OR   = 6'b101010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MUL  = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    function automatic logic [2:0] decode(input logic [1:0] op, input logic [5:0] f);
        return op == OP_MEM    ? CTL_ADD :
               op == OP_BRANCH ? CTL_SUB :
               op == OP_RES    ? CTL_FORWARD :
               f == F_OR   ? CTL_OR   :
               f == F_ADD  ? CTL_ADD  :
               f == F_SUB  ? CTL_SUB  :
               f == F_MUL  ? CTL_MUL  :
               f == F_DIV  ? CTL_DIV  :
               f == F_MFHI ? CTL_MFHI :
               f == F_MFLO ? CTL_MFLO : CTL_FORWARD;
    endfunction
endpackage

// File: rtl/alu_muldiv_control_if.sv
// alu_muldiv_control_if: EX-stage request/response bundle between pipeline and ALU control
interface alu_muldiv_control_if #(parameter int WIDTH = 32);
    logic             valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             stall;
    logic             div_by_zero;
    modport master (output valid, alu_op, funct, a, b,
                    input  alu_ctl, hilo_out, busy, stall, div_by_zero);
    modport slave  (input  valid, alu_op, funct, a, b,
                    output alu_ctl, hilo_out, busy, stall, div_by_zero);
endinterface

// File: rtl/alu_muldiv_control_muldiv_iter.sv
// muldiv_iter: one iteration of shift-add multiply or restoring divide on the {hi,lo} accumulator
module muldiv_iter #(parameter int WIDTH = 32) (
    input  logic               mode,
    input  logic               step,
    input  logic               last,
    input  logic [WIDTH-1:0]   opnd,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               done
);
    logic [WIDTH:0] sum, rsh, diff;
    // mode=0: add multiplicand on lsb then shift right; mode=1: shift left and trial-subtract divisor
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rsh     = acc[2*WIDTH-1:WIDTH-1];
        diff    = rsh - {1'b0, opnd};
        acc_nxt = !step ? acc :
                  !mode ? {sum, acc[WIDTH-1:1]} :
                  diff[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        done    = step & last;
    end
endmodule

// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control: ALUCtl decode, HI/LO registers and iterative MUL/DIV sequencer with stall (SIGNED_MULDIV_EN selects signed MUL/DIV)
module alu_muldiv_control
    import alu_muldiv_control_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    alu_muldiv_control_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   opnd, hi, lo, fin_hi, fin_lo, mag_a, mag_b;
    logic [2:0]         ctl;
    logic               accept, dbz_now, dbz, busy, done;

    assign ctl     = decode(bus.alu_op, bus.funct);
    assign busy    = state != S_IDLE;
    assign accept  = state == S_IDLE && bus.valid && (ctl == CTL_MUL || ctl == CTL_DIV);
    assign dbz_now = accept && ctl == CTL_DIV && bus.b == '0;

`ifdef SIGNED_MULDIV_EN
    logic               sa, sb;
    logic [2*WIDTH-1:0] prod;
    assign mag_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign mag_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign prod   = (sa ^ sb) ? -acc_nxt : acc_nxt;
    assign fin_hi = state == S_DIV ? (sa ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH])
                                   : prod[2*WIDTH-1:WIDTH];
    assign fin_lo = state == S_DIV ? ((sa ^ sb) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0])
                                   : prod[WIDTH-1:0];
`else
    assign mag_a  = bus.a;
    assign mag_b  = bus.b;
    assign fin_hi = acc_nxt[2*WIDTH-1:WIDTH];
    assign fin_lo = acc_nxt[WIDTH-1:0];
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .mode    (state == S_DIV),
        .step    (busy),
        .last    (cnt == CNT_W'(1)),
        .opnd    (opnd),
        .acc     (acc),
        .acc_nxt (acc_nxt),
        .done    (done)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next state: launch on accepted MUL/DIV (not divide-by-zero), return to idle on final iteration
    always_comb state_nxt = done ? S_IDLE :
                            (accept && !dbz_now) ? (ctl == CTL_MUL ? S_MUL : S_DIV) : state;

    // operand latch, iteration counter, accumulator and HI/LO write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            acc  <= '0;
            opnd <= '0;
            hi   <= '0;
            lo   <= '0;
            dbz  <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            sa   <= 1'b0;
            sb   <= 1'b0;
`endif
        end else begin
            dbz <= dbz_now;
            if (accept && !dbz_now) begin
                cnt  <= CNT_W'(WIDTH);
                opnd <= ctl == CTL_MUL ? mag_a : mag_b;
                acc  <= {{WIDTH{1'b0}}, (ctl == CTL_MUL ? mag_b : mag_a)};
`ifdef SIGNED_MULDIV_EN
                sa   <= bus.a[WIDTH-1];
                sb   <= bus.b[WIDTH-1];
`endif
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
                acc <= acc_nxt;
            end
            if (done) begin
                hi <= fin_hi;
                lo <= fin_lo;
            end
            if (dbz_now) begin
                hi <= bus.a;
                lo <= '1;
            end
        end
    end

    // outputs: decode, HI/LO read port and stall, all forced quiet during reset
    always_comb begin
        bus.busy        = busy;
        bus.div_by_zero = dbz;
        bus.alu_ctl     = rst ? CTL_FORWARD : ctl;
        bus.stall       = !rst && bus.valid && busy &&
                          (ctl == CTL_MUL || ctl == CTL_DIV || ctl == CTL_MFHI || ctl == CTL_MFLO);
        bus.hilo_out    = (rst || busy) ? '0 :
                          ctl == CTL_MFHI ? hi :
                          ctl == CTL_MFLO ? lo : '0;
    end
endmodule

// File: tb/tb_alu_muldiv_control.sv
// tb_alu_muldiv_control: directed self-checking bench for decode, MUL/DIV sequencing, stall and reset
module tb_alu_muldiv_control;
    localparam logic [5:0] MUL = 6'h18, DIV = 6'h1A, MFHI = 6'h10, MFLO = 6'h12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   n;

    alu_muldiv_control_if #(.WIDTH(32)) bus();

    alu_muldiv_control #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_ctl(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00: return 3'd2;
            2'b01: return 3'd6;
            2'b11: return 3'd0;
            default:
                case (f)
                    6'h2A: return 3'd1;
                    6'h20: return 3'd2;
                    6'h22: return 3'd6;
                    6'h18: return 3'd5;
                    6'h1A: return 3'd7;
                    6'h10: return 3'd3;
                    6'h12: return 3'd4;
                    default: return 3'd0;
                endcase
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'h00; bus.a = '0; bus.b = '0;
    endtask

    task automatic set_r(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.valid = v; bus.alu_op = 2'b10; bus.funct = f; bus.a = a; bus.b = b;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy);
        int k = 0;
        @(negedge clk); set_r(1'b1, f, a, b);
        @(negedge clk); idle_in();
        while (bus.busy && k < 200) begin k++; @(negedge clk); end
        chk({tag, " busy cycles"}, 64'(k), 64'(exp_busy));
    endtask

    task automatic read_hl(input string tag, input logic [5:0] f, input logic [31:0] exp);
        set_r(1'b1, f, '0, '0);
        #1;
        chk(tag, bus.hilo_out, exp);
        chk({tag, " ctl"}, bus.alu_ctl, (f == MFHI) ? 64'd3 : 64'd4);
        idle_in();
        #1;
    endtask

    initial begin
        idle_in();
        #1 rst = 1'b1;
        #2;
        set_r(1'b1, MFHI, 32'h1, 32'h2);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset stall", bus.stall, 0);
        chk("reset dbz", bus.div_by_zero, 0);
        chk("reset alu_ctl", bus.alu_ctl, 0);
        chk("reset hilo_out", bus.hilo_out, 0);
        idle_in();
        @(negedge clk); rst = 1'b0;

        for (int op = 0; op < 4; op++)
            for (int f = 0; f < 64; f++) begin
                @(negedge clk);
                bus.valid = 1'b0; bus.alu_op = 2'(op); bus.funct = 6'(f);
                #1;
                chk("decode", bus.alu_ctl, exp_ctl(2'(op), 6'(f)));
            end
        idle_in();

        run_op("mul 2^16*2^16", MUL, 32'h0001_0000, 32'h0001_0000, 32);
        read_hl("mul 2^16 hi", MFHI, 32'h1);
        read_hl("mul 2^16 lo", MFLO, 32'h0);

        run_op("mul max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        read_hl("mul max hi", MFHI, 32'hFFFF_FFFE);
        read_hl("mul max lo", MFLO, 32'h0000_0001);

        run_op("div 100/7", DIV, 32'd100, 32'd7, 32);
        read_hl("div 100/7 hi", MFHI, 32'd2);
        read_hl("div 100/7 lo", MFLO, 32'd14);

        run_op("div 3/10", DIV, 32'd3, 32'd10, 32);
        read_hl("div 3/10 hi", MFHI, 32'd3);
        read_hl("div 3/10 lo", MFLO, 32'd0);

        run_op("div -100/7", DIV, 32'hFFFF_FF9C, 32'd7, 32);
`ifdef SIGNED_MULDIV_EN
        read_hl("div -100/7 hi", MFHI, 32'hFFFF_FFFE);
        read_hl("div -100/7 lo", MFLO, 32'hFFFF_FFF2);
`else
        read_hl("div -100/7 hi", MFHI, 32'd2);
        read_hl("div -100/7 lo", MFLO, 32'h2492_4916);
`endif

        @(negedge clk); set_r(1'b1, DIV, 32'd5, 32'd0);
        #1 chk("dbz no stall", bus.stall, 0);
        @(negedge clk); idle_in();
        chk("dbz pulse", bus.div_by_zero, 1);
        chk("dbz busy", bus.busy, 0);
        @(negedge clk);
        chk("dbz pulse end", bus.div_by_zero, 0);
        chk("dbz busy later", bus.busy, 0);
        read_hl("dbz hi", MFHI, 32'd5);
        read_hl("dbz lo", MFLO, 32'hFFFF_FFFF);

        @(negedge clk); set_r(1'b1, MUL, 32'd5, 32'd6);
        @(negedge clk); idle_in();
        @(negedge clk);
        @(negedge clk); set_r(1'b1, MFLO, '0, '0);
        #1;
        chk("mflo stall", bus.stall, 1);
        chk("mflo stalled out", bus.hilo_out, 0);
        n = 0;
        while (bus.stall && n < 200) begin @(negedge clk); n++; #1; end
        chk("mflo stall cycles", 64'(n), 30);
        chk("mflo release busy", bus.busy, 0);
        chk("mflo release data", bus.hilo_out, 32'd30);
        chk("mflo release ctl", bus.alu_ctl, 4);
        idle_in();

        @(negedge clk); set_r(1'b1, MUL, 32'd2, 32'd3);
        @(negedge clk); idle_in();
        @(negedge clk); set_r(1'b1, MUL, 32'd7, 32'd8);
        #1 chk("b2b stall", bus.stall, 1);
        n = 0;
        while (bus.stall && n < 200) begin @(negedge clk); n++; #1; end
        chk("b2b stall cycles", 64'(n), 31);
        chk("b2b release busy", bus.busy, 0);
        @(negedge clk); idle_in();
        chk("b2b accepted", bus.busy, 1);
        n = 0;
        while (bus.busy && n < 200) begin n++; @(negedge clk); end
        chk("b2b busy cycles", 64'(n), 32);
        read_hl("b2b lo", MFLO, 32'd56);
        read_hl("b2b hi", MFHI, 32'd0);

        @(negedge clk); set_r(1'b1, DIV, 32'd100, 32'd7);
        @(negedge clk); idle_in();
        repeat (9) @(negedge clk);
        chk("pre-reset busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset busy", bus.busy, 0);
        set_r(1'b1, MFLO, '0, '0);
        #1;
        chk("in-reset alu_ctl", bus.alu_ctl, 0);
        chk("in-reset hilo_out", bus.hilo_out, 0);
        idle_in();
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("post-reset busy", bus.busy, 0);
        read_hl("post-reset hi", MFHI, 32'd0);
        read_hl("post-reset lo", MFLO, 32'd0);

        run_op("mul 3*4", MUL, 32'd3, 32'd4, 32);
        read_hl("mul 3*4 lo", MFLO, 32'd12);
        read_hl("mul 3*4 hi", MFHI, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
